cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture.sv | 159 +++++++++++++++
 tb/tb_cam_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// Camera frame grabber: on a shutter edge, waits for the next frame and assembles
// RGB565 byte pairs into addressed pixel strobes for a framebuffer.
module cam_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int AW     = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fpga_href,
  input  logic          fpga_vsync,
  input  logic [7:0]    fpga_data,
  input  logic          fpga_shutter,
  output logic          pix_valid,
  output logic [15:0]   pix_data,
  output logic [AW-1:0] pix_addr,
  output logic          busy,
  output logic          frame_done,
  output logic          line_err,
  output logic          ovf_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // One spare bit so x can count past WIDTH without wrapping into the valid range.
  localparam int XW = $clog2(WIDTH) + 1;
  localparam int YW = $clog2(HEIGHT + 1);

  logic [1:0]    state_q, state_d;
  logic          vsync_q, shutter_q, href_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          pix_valid_q, pix_valid_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic          line_err_q, line_err_d;
  logic          ovf_err_q, ovf_err_d;

  logic vsync_rise, vsync_fall, shutter_rise, href_fall;

  assign vsync_rise   = fpga_vsync & ~vsync_q;
  assign vsync_fall   = ~fpga_vsync & vsync_q;
  assign shutter_rise = fpga_shutter & ~shutter_q;
  assign href_fall    = ~fpga_href & href_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_addr_d  = pix_addr_q;
    line_err_d  = line_err_q;
    ovf_err_d   = ovf_err_q;

    case (state_q)
      IDLE: begin
        if (shutter_rise) state_d = ARMED;
      end
      ARMED: begin
        if (vsync_fall) begin
          state_d    = CAPTURE;
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          phase_d    = 1'b0;
          line_err_d = 1'b0;
          ovf_err_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (fpga_href) begin
          if (!phase_q) begin
            hi_d    = fpga_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < XW'(WIDTH)) && (y_q < YW'(HEIGHT))) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, fpga_data};
              pix_addr_d  = row_base_q + AW'(x_q);
            end else begin
              ovf_err_d = 1'b1;
            end
            if (x_q != '1) x_d = x_q + 1'b1;
          end
        end else if (href_fall) begin
          // An odd trailing byte is discarded by forcing the phase back to the high byte.
          phase_d = 1'b0;
          if (x_q != '0) begin
            if (x_q != XW'(WIDTH)) line_err_d = 1'b1;
            x_d = '0;
            if (y_q < YW'(HEIGHT)) begin
              y_d        = y_q + 1'b1;
              row_base_d = row_base_q + AW'(WIDTH);
            end
          end
        end
        if (vsync_rise) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      shutter_q   <= 1'b0;
      href_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_addr_q  <= '0;
      line_err_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= fpga_vsync;
      shutter_q   <= fpga_shutter;
      href_q      <= fpga_href;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_addr_q  <= pix_addr_d;
      line_err_q  <= line_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_addr   = pix_addr_q;
  assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
  assign frame_done = (state_q == DONE);
  assign line_err   = line_err_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture with a 4x2 framebuffer: stimulus pushes expected
// pixels, a negedge monitor pops and compares every strobe.
module tb_cam_capture;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fpga_href = 1'b0;
  logic          fpga_vsync = 1'b1;
  logic [7:0]    fpga_data = 8'h00;
  logic          fpga_shutter = 1'b0;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          busy, frame_done, line_err, ovf_err;

  int compared = 0;
  int mismatched = 0;
  int fd_count = 0;
  logic [15:0]   exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  cam_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .fpga_href(fpga_href), .fpga_vsync(fpga_vsync),
    .fpga_data(fpga_data), .fpga_shutter(fpga_shutter), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_addr(pix_addr), .busy(busy), .frame_done(frame_done),
    .line_err(line_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && pix_valid) begin
      compared++;
      if (exp_data_q.size() == 0) begin
        mismatched++;
        $display("FAIL pix_unexpected: got data=%h addr=%0d, required no strobe", pix_data, pix_addr);
      end else begin
        logic [15:0]   ed;
        logic [AW-1:0] ea;
        ed = exp_data_q.pop_front();
        ea = exp_addr_q.pop_front();
        if (pix_data !== ed || pix_addr !== ea) begin
          mismatched++;
          $display("FAIL pix: got data=%h addr=%0d, required data=%h addr=%0d", pix_data, pix_addr, ed, ea);
        end else begin
          $display("pix ok: data=%h addr=%0d", pix_data, pix_addr);
        end
      end
    end
    if (!reset && frame_done) fd_count++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check ok: %s = %h", name, act);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [AW-1:0] a);
    exp_data_q.push_back(d);
    exp_addr_q.push_back(a);
  endtask

  task automatic send_line(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fpga_href = 1'b1;
      fpga_data = first + 8'(i);
      step();
    end
    fpga_href = 1'b0;
    fpga_data = 8'h00;
    step(3);
  endtask

  task automatic shutter_pulse();
    fpga_shutter = 1'b1;
    step(2);
    fpga_shutter = 1'b0;
    step(2);
  endtask

  task automatic start_frame();
    fpga_vsync = 1'b0;
    step(2);
  endtask

  task automatic end_frame();
    fpga_vsync = 1'b1;
    step(4);
  endtask

  initial begin
    int fd_before;
    // Reset with shutter held low.
    step(3);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    reset = 1'b0;
    step(3);

    // Frame traffic without shutter: nothing captured.
    start_frame();
    send_line(8'h01, 8);
    chk("noshut_busy", 32'(busy), 32'd0);
    send_line(8'h09, 8);
    end_frame();
    chk("noshut_frame_done", 32'(fd_count), 32'd0);

    // Nominal 4x2 frame.
    shutter_pulse();
    chk("armed_busy", 32'(busy), 32'd1);
    start_frame();
    chk("capture_busy", 32'(busy), 32'd1);
    push(16'h0102, 3'd0); push(16'h0304, 3'd1); push(16'h0506, 3'd2); push(16'h0708, 3'd3);
    send_line(8'h01, 8);
    push(16'h090A, 3'd4); push(16'h0B0C, 3'd5); push(16'h0D0E, 3'd6); push(16'h0F10, 3'd7);
    send_line(8'h09, 8);
    end_frame();
    chk("nom_frame_done_cnt", 32'(fd_count), 32'd1);
    chk("nom_line_err", 32'(line_err), 32'd0);
    chk("nom_ovf_err", 32'(ovf_err), 32'd0);
    chk("nom_busy_after", 32'(busy), 32'd0);
    chk("nom_hold_data", 32'(pix_data), 32'h0F10);
    chk("nom_hold_addr", 32'(pix_addr), 32'd7);
    chk("nom_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Short line: 6 bytes -> 3 pixels and line_err; next line starts at 4.
    shutter_pulse();
    start_frame();
    push(16'h2122, 3'd0); push(16'h2324, 3'd1); push(16'h2526, 3'd2);
    send_line(8'h21, 6);
    chk("short_line_err", 32'(line_err), 32'd1);
    push(16'h3132, 3'd4); push(16'h3334, 3'd5); push(16'h3536, 3'd6); push(16'h3738, 3'd7);
    send_line(8'h31, 8);
    end_frame();
    chk("short_ovf_err", 32'(ovf_err), 32'd0);
    chk("short_frame_done_cnt", 32'(fd_count), 32'd2);
    chk("short_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Long line overflows, then odd 7-byte line drops its trailing byte.
    shutter_pulse();
    start_frame();
    chk("clear_line_err", 32'(line_err), 32'd0);
    push(16'h4142, 3'd0); push(16'h4344, 3'd1); push(16'h4546, 3'd2); push(16'h4748, 3'd3);
    send_line(8'h41, 10);
    chk("long_ovf_err", 32'(ovf_err), 32'd1);
    push(16'h5152, 3'd4); push(16'h5354, 3'd5); push(16'h5556, 3'd6);
    send_line(8'h51, 7);
    end_frame();
    chk("long_frame_done_cnt", 32'(fd_count), 32'd3);
    chk("long_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Reset mid-capture after 3 pixels; a shutter edge during capture is not queued.
    shutter_pulse();
    start_frame();
    fpga_shutter = 1'b1;
    push(16'h6162, 3'd0); push(16'h6364, 3'd1); push(16'h6566, 3'd2);
    send_line(8'h61, 6);
    fpga_shutter = 1'b0;
    fd_before = fd_count;
    reset = 1'b1;
    step(2);
    chk("abort_pix_valid", 32'(pix_valid), 32'd0);
    chk("abort_pix_data", 32'(pix_data), 32'd0);
    chk("abort_pix_addr", 32'(pix_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_line_err", 32'(line_err), 32'd0);
    chk("abort_ovf_err", 32'(ovf_err), 32'd0);
    reset = 1'b0;
    end_frame();
    chk("abort_no_frame_done", 32'(fd_count), 32'(fd_before));
    start_frame();
    send_line(8'h71, 8);
    chk("post_abort_busy", 32'(busy), 32'd0);
    end_frame();
    chk("post_abort_no_frame_done", 32'(fd_count), 32'(fd_before));
    chk("final_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
